sbox_share_arbiter: RTL and testbench
=====================================

Name: sbox_share_arbiter

Overview:
- Sequencer and arbiter that shares the single 4-cycle subBytes datapath between two requesters:
  - the cipher round pipeline, which needs a full 128-bit state;
  - the key-expansion unit, which needs a 32-bit SubWord.
- Blocks all use until the S-box RAM reports ready, then issues one operation at a time, holds operands stable, captures the result, and returns it with a done pulse.

Parameters:
- TIMEOUT, 15, maximum cycles in WAIT without sb_out_ready before the operation is aborted.
- TW, 4, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- sbox_ready  in  1  S-box RAM initialised (subBytes s_box_ready).
- rnd_req  in  1  round requester request; level, held until rnd_done.
- rnd_data  in  [0:127]  round state; stable while rnd_req=1.
- rnd_gnt  out  1  round requester owns the datapath.
- rnd_done  out  1  one-cycle pulse; rnd_result valid.
- rnd_result  out  [0:127]  substituted state.
- key_req  in  1  key-expansion request; level, held until key_done.
- key_word  in  [0:31]  word to substitute; stable while key_req=1.
- key_gnt  out  1  key requester owns the datapath.
- key_done  out  1  one-cycle pulse; key_result valid.
- key_result  out  [0:31]  substituted word.
- sb_in_data  out  [0:127]  operand to subBytes in_data.
- sb_in_ready  out  1  start pulse to subBytes in_ready.
- sb_out_data  in  [0:127]  subBytes out_data.
- sb_out_ready  in  1  subBytes out_ready.
- busy  out  1  state is ISSUE, WAIT or RESP.
- timeout_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- **Reset** (synchronous, active-high; also applies mid-operation):
  - state=INIT, last_owner=RND, so KEY wins the first tie;
  - all outputs 0, including sb_in_data, results, timeout_err and the timeout counter;
  - any in-flight operation is abandoned; no done pulse is issued.
- **States:** INIT, IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **INIT:** remain until sbox_ready=1, then go to IDLE. Requests are ignored in INIT.
- **IDLE** (no grants asserted):
  - if sbox_ready=0, stay in IDLE;
  - else if exactly one request is high, select it;
  - if both are high, select the one not equal to last_owner (round-robin);
  - on selection, in the same edge: load sb_in_data, set the matching gnt, set sb_in_ready=1, go to ISSUE.
- **Operand formatting:**
  - RND: sb_in_data = rnd_data.
  - KEY: sb_in_data[0:31] = key_word; [32:127] = 0.
- **ISSUE** (exactly 1 cycle): sb_in_ready is 1 for this cycle only; next edge clears it, clears the timeout counter, and goes to WAIT.
- **WAIT:**
  - sb_in_data is held unchanged; subBytes samples it across 4 cycles.
  - The counter increments every cycle.
  - On sb_out_ready=1:
    - capture into the owner's result register: RND takes all 128 bits; KEY takes sb_out_data[0:31];
    - pulse the owner's done next cycle; go to RESP.
  - If the counter reaches TIMEOUT with sb_out_ready=0:
    - set timeout_err=1; the owner's result register is cleared to 0;
    - pulse done; go to RESP.
  - If sb_out_ready and the timeout coincide, the result wins and timeout_err is not set.
- **RESP** (1 cycle):
  - the owner's done=1 and gnt is still 1;
  - next edge: clear gnt and done, set last_owner=owner, go to IDLE.
- **Gap between operations:** at least 1 IDLE cycle separates them. A requester whose req is still high in IDLE after its done is treated as a new request.
- **Ownership:** gnt is high from ISSUE through RESP inclusive; both gnts are never high together.
- **Output stability:** result registers hold their value until the next capture or reset.
- **Stray inputs:**
  - sb_out_ready outside WAIT is ignored.
  - A request dropped before done is not cancelled; done still pulses.
- **sbox_ready** falling outside INIT has no effect on an operation in flight; it only blocks new grants in IDLE.
- **Latency:** rnd_done/key_done fires 1 cycle after sb_out_ready. ISSUE occurs 1 cycle after the request is seen in IDLE.

Test Plan:
- **Gate on RAM init:** hold sbox_ready=0 for 300 cycles with key_req=1 -> no gnt, no sb_in_ready. Raise sbox_ready -> key_gnt plus one sb_in_ready pulse within 2 cycles.
- **Key word:** key_word=32'h00000000 -> sb_in_data=128'h0000_0000 followed by zeros. key_result=32'h63636363 and key_done is a single pulse 1 cycle after sb_out_ready. rnd_done stays 0.
- **Round state:** rnd_data=128'h5353…53 (all bytes 0x53) -> rnd_result=128'hEDED…ED and a single rnd_done. sb_in_data is constant from ISSUE to RESP.
- **Contention:** both requests high continuously from reset -> grant order KEY, RND, KEY, RND, with ≥1 IDLE cycle between. Gnts are never simultaneous and sb_in_ready pulses exactly once per grant.
- **Timeout:** model never asserts sb_out_ready -> after TIMEOUT=15 WAIT cycles, done pulses with result=0 and timeout_err=1 stays set. The next request is served normally and timeout_err remains 1 until reset.
- **Reset mid-operation:** assert reset in WAIT -> next cycle all outputs 0, state INIT, no done pulse. After sbox_ready the pending request is re-issued from the start.

Source files
------------

// File: rtl/sbox_share_arbiter.sv
// Purpose: time-shares one 4-cycle subBytes datapath between the round pipeline (128-bit) and key expansion (32-bit).
// Latency: ISSUE one cycle after a request is seen in IDLE; done one cycle after sb_out_ready (or after the WAIT timeout).
// Backpressure: requests are levels held until done; one operation in flight, round-robin on ties, nothing granted until sbox_ready.
module sbox_share_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sbox_ready,
   input  logic         rnd_req,
   input  logic [0:127] rnd_data,
   output logic         rnd_gnt,
   output logic         rnd_done,
   output logic [0:127] rnd_result,
   input  logic         key_req,
   input  logic [0:31]  key_word,
   output logic         key_gnt,
   output logic         key_done,
   output logic [0:31]  key_result,
   output logic [0:127] sb_in_data,
   output logic         sb_in_ready,
   input  logic [0:127] sb_out_data,
   input  logic         sb_out_ready,
   output logic         busy,
   output logic         timeout_err
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state, state_nxt;
   logic          owner_key, owner_key_nxt;   // 1: key requester owns the current operation
   logic          last_key, last_key_nxt;     // 1: key requester was served last
   logic [TW-1:0] cnt, cnt_nxt;
   logic          start, pick_key, wait_hit, wait_to;

   logic [0:127]  sb_in_data_nxt, rnd_result_nxt;
   logic [0:31]   key_result_nxt;
   logic          sb_in_ready_nxt, rnd_gnt_nxt, key_gnt_nxt;
   logic          rnd_done_nxt, key_done_nxt, busy_nxt, timeout_err_nxt;

   // Request selection and the two ways out of WAIT; a response on the timeout cycle wins.
   always_comb begin
      pick_key = key_req && (!rnd_req || !last_key);
      start    = (state == S_IDLE) && sbox_ready && (rnd_req || key_req);
      wait_hit = (state == S_WAIT) && sb_out_ready;
      wait_to  = (state == S_WAIT) && !sb_out_ready && (cnt == TW'(TIMEOUT - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (sbox_ready) state_nxt = S_IDLE;
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (wait_hit || wait_to) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_INIT;
      endcase
   end

   // Next values of every registered output and of the bookkeeping registers.
   always_comb begin
      sb_in_data_nxt  = sb_in_data;
      sb_in_ready_nxt = 1'b0;
      rnd_gnt_nxt     = rnd_gnt;
      key_gnt_nxt     = key_gnt;
      rnd_done_nxt    = 1'b0;
      key_done_nxt    = 1'b0;
      rnd_result_nxt  = rnd_result;
      key_result_nxt  = key_result;
      timeout_err_nxt = timeout_err | wait_to;
      owner_key_nxt   = owner_key;
      last_key_nxt    = last_key;
      cnt_nxt         = cnt;
      busy_nxt        = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) || (state_nxt == S_RESP);

      if (start) begin
         owner_key_nxt   = pick_key;
         sb_in_data_nxt  = pick_key ? {key_word, 96'b0} : rnd_data;
         sb_in_ready_nxt = 1'b1;
         key_gnt_nxt     = pick_key;
         rnd_gnt_nxt     = !pick_key;
      end

      if (state == S_ISSUE) cnt_nxt = '0;
      if (state == S_WAIT)  cnt_nxt = cnt + TW'(1);

      if (wait_hit || wait_to) begin
         key_done_nxt = owner_key;
         rnd_done_nxt = !owner_key;
         if (owner_key) key_result_nxt = wait_hit ? sb_out_data[0:31] : 32'b0;
         else           rnd_result_nxt = wait_hit ? sb_out_data : 128'b0;
      end

      if (state == S_RESP) begin
         rnd_gnt_nxt  = 1'b0;
         key_gnt_nxt  = 1'b0;
         last_key_nxt = owner_key;
      end
   end

   // Output and bookkeeping registers; reset abandons any operation without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_in_data  <= '0;
         sb_in_ready <= 1'b0;
         rnd_gnt     <= 1'b0;
         key_gnt     <= 1'b0;
         rnd_done    <= 1'b0;
         key_done    <= 1'b0;
         rnd_result  <= '0;
         key_result  <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         owner_key   <= 1'b0;
         last_key    <= 1'b0;
         cnt         <= '0;
      end else begin
         sb_in_data  <= sb_in_data_nxt;
         sb_in_ready <= sb_in_ready_nxt;
         rnd_gnt     <= rnd_gnt_nxt;
         key_gnt     <= key_gnt_nxt;
         rnd_done    <= rnd_done_nxt;
         key_done    <= key_done_nxt;
         rnd_result  <= rnd_result_nxt;
         key_result  <= key_result_nxt;
         busy        <= busy_nxt;
         timeout_err <= timeout_err_nxt;
         owner_key   <= owner_key_nxt;
         last_key    <= last_key_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Bench for sbox_share_arbiter: directed table, multi-cycle corner sequences, randomized traffic vs a transaction model.
// The subBytes datapath is modelled here with a GF(2^8) S-box and a programmable response latency.
// Latency 0 in the responder means the datapath never answers.
module tb_sbox_share_arbiter;
   localparam int TIMEOUT = 15;
   localparam int TW      = 4;

   logic         clk = 1'b0;
   logic         reset, sbox_ready, rnd_req, key_req, sb_out_ready;
   logic [0:127] rnd_data, sb_out_data, rnd_result, sb_in_data;
   logic [0:31]  key_word, key_result;
   logic         rnd_gnt, rnd_done, key_gnt, key_done, sb_in_ready, busy, timeout_err;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   logic [7:0]   sbt [256];
   int           lat_cfg = 4, cd = 0;
   logic [127:0] op;

   sbox_share_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .reset(reset), .sbox_ready(sbox_ready),
      .rnd_req(rnd_req), .rnd_data(rnd_data), .rnd_gnt(rnd_gnt), .rnd_done(rnd_done), .rnd_result(rnd_result),
      .key_req(key_req), .key_word(key_word), .key_gnt(key_gnt), .key_done(key_done), .key_result(key_result),
      .sb_in_data(sb_in_data), .sb_in_ready(sb_in_ready), .sb_out_data(sb_out_data), .sb_out_ready(sb_out_ready),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(logic [7:0] v);
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub128(logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbt[v[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(string tag);
      chk({tag, " ctl"}, 128'({rnd_gnt, key_gnt, rnd_done, key_done, sb_in_ready, busy, timeout_err}), 128'h0);
      chk({tag, " sb_in_data"}, sb_in_data, 128'h0);
      chk({tag, " rnd_result"}, rnd_result, 128'h0);
      chk({tag, " key_result"}, 128'(key_result), 128'h0);
   endtask

   // One clock; outputs are observed 1 time unit after the edge. Also runs the subBytes responder.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      sb_out_ready = 1'b0;
      if (sb_in_ready) begin
         op = sb_in_data;
         cd = lat_cfg;
      end else if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            sb_out_ready = 1'b1;
            sb_out_data  = sub128(op);
         end
      end
   endtask

   typedef struct {
      logic         is_key;
      logic [127:0] dat;      // key word in [31:0] for key entries
      int           lat;
      logic [127:0] exp_res;  // key result in [31:0] for key entries
      logic         exp_err;
   } vec_t;

   localparam int NV = 7;
   vec_t vec [NV];

   initial begin
      int t_iss, t_done, n_iss, n_own, n_oth, n_unst, n_gr, n_both, n_b2b;
      int order [8];
      logic prev_any, prev_r, prev_k;
      logic [127:0] exp_op, got_res, exp_res, inf_op;
      logic got_err, p_idle, p_rr, p_kr, p_sr, exp_start, exp_due, inf, inf_key, last_key_m, err_m;
      logic rnd_pend, key_pend;
      int inf_lat, t0;

      for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));

      vec[0] = '{1'b1, 128'h0000_0000,              4,  128'h6363_6363,              1'b0};
      vec[1] = '{1'b0, {16{8'h53}},                 4,  {16{8'hED}},                 1'b0};
      vec[2] = '{1'b1, 128'h0001_0203,              1,  128'h637C_777B,              1'b0};
      vec[3] = '{1'b0, {8{16'h10FF}},               15, {8{16'hCA16}},               1'b0};
      vec[4] = '{1'b1, 128'h5320_1011,              7,  128'hEDB7_CA82,              1'b0};
      vec[5] = '{1'b0, {16{8'h01}},                 0,  128'h0,                      1'b1};
      vec[6] = '{1'b1, 128'h2020_2020,              3,  128'hB7B7_B7B7,              1'b1};

      reset = 1'b1; sbox_ready = 1'b0; rnd_req = 1'b0; key_req = 1'b0;
      rnd_data = '0; key_word = '0; sb_out_ready = 1'b0; sb_out_data = '0;
      repeat (3) tick();
      chk_zero("reset");

      // Nothing may be granted while the S-box RAM is still initialising.
      reset = 1'b0; key_req = 1'b1; key_word = 32'h0; lat_cfg = 4;
      n_iss = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (rnd_gnt || key_gnt || sb_in_ready) n_iss++;
      end
      chk_i("gate no grant", n_iss, 0);
      sbox_ready = 1'b1;
      t_iss = -1; n_iss = 0; n_own = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (sb_in_ready) begin
            n_iss++;
            if (t_iss < 0) begin t_iss = k; chk("gate key_gnt", 128'({key_gnt, rnd_gnt}), 128'b10); end
         end
         if (key_done) begin n_own++; key_req = 1'b0; end
      end
      chk_i("gate issue tick", t_iss, 1);
      chk_i("gate issue pulses", n_iss, 1);
      chk_i("gate done pulses", n_own, 1);

      // Table of single operations.
      for (int i = 0; i < NV; i++) begin
         lat_cfg = vec[i].lat;
         exp_op  = vec[i].is_key ? {vec[i].dat[31:0], 96'b0} : vec[i].dat;
         if (vec[i].is_key) begin key_word = vec[i].dat[31:0]; key_req = 1'b1; end
         else begin rnd_data = vec[i].dat; rnd_req = 1'b1; end
         t_iss = -1; t_done = -1; n_iss = 0; n_own = 0; n_oth = 0; n_unst = 0; got_res = '1; got_err = 1'bx;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (sb_in_ready) begin n_iss++; if (t_iss < 0) t_iss = k; end
            if ((rnd_gnt || key_gnt) && sb_in_data !== exp_op) n_unst++;
            if (vec[i].is_key ? key_done : rnd_done) begin
               n_own++; t_done = k; got_err = timeout_err;
               got_res = vec[i].is_key ? {96'b0, key_result} : rnd_result;
               key_req = 1'b0; rnd_req = 1'b0;
            end
            if (vec[i].is_key ? rnd_done : key_done) n_oth++;
         end
         chk_i($sformatf("vec%0d issue tick", i), t_iss, 0);
         chk_i($sformatf("vec%0d issue pulses", i), n_iss, 1);
         chk_i($sformatf("vec%0d done tick", i), t_done, (vec[i].lat == 0) ? TIMEOUT + 1 : vec[i].lat + 1);
         chk_i($sformatf("vec%0d done pulses", i), n_own, 1);
         chk_i($sformatf("vec%0d other done", i), n_oth, 0);
         chk_i($sformatf("vec%0d operand changes", i), n_unst, 0);
         chk($sformatf("vec%0d result", i), got_res, vec[i].exp_res);
         chk($sformatf("vec%0d timeout_err", i), 128'(got_err), 128'(vec[i].exp_err));
      end

      // Contention from reset: key wins first, then strict alternation with an idle gap.
      reset = 1'b1; rnd_req = 1'b1; key_req = 1'b1; rnd_data = {16{8'h53}}; key_word = 32'h0;
      sbox_ready = 1'b1; lat_cfg = 4; cd = 0;
      tick();
      chk_zero("reset again");
      reset = 1'b0;
      n_gr = 0; n_iss = 0; n_both = 0; n_b2b = 0; prev_any = 1'b0; prev_r = 1'b0; prev_k = 1'b0;
      for (int j = 0; j < 8; j++) order[j] = -1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (rnd_gnt && key_gnt) n_both++;
         if (sb_in_ready) n_iss++;
         if ((rnd_gnt && !prev_r) || (key_gnt && !prev_k)) begin
            if (prev_any) n_b2b++;
            if (n_gr < 8) order[n_gr] = int'(key_gnt);
            n_gr++;
         end
         prev_r = rnd_gnt; prev_k = key_gnt; prev_any = rnd_gnt || key_gnt;
      end
      chk_i("contend at least 4 grants", int'(n_gr >= 4), 1);
      for (int j = 0; j < 4; j++) chk_i($sformatf("contend order %0d (1=key)", j), order[j], (j % 2 == 0) ? 1 : 0);
      chk_i("contend issue pulses per grant", n_iss, n_gr);
      chk_i("contend both gnts", n_both, 0);
      chk_i("contend back-to-back grants", n_b2b, 0);
      chk("contend rnd_result", rnd_result, {16{8'hED}});
      rnd_req = 1'b0; key_req = 1'b0;
      repeat (20) tick();

      // Reset while waiting on the datapath, then the held request is re-issued from scratch.
      lat_cfg = 0; rnd_data = {16{8'h01}}; rnd_req = 1'b1;
      t0 = 0;
      for (int k = 0; k < 10 && !sb_in_ready; k++) tick();
      chk("midop issued", 128'(sb_in_ready), 128'b1);
      n_own = 0;
      repeat (3) begin tick(); if (rnd_done || key_done) n_own++; end
      chk("midop in wait busy", 128'(busy), 128'b1);
      reset = 1'b1;
      tick();
      if (rnd_done || key_done) n_own++;
      chk_zero("midop reset");
      reset = 1'b0; cd = 0; lat_cfg = 2;
      t_iss = -1; t_done = -1; n_iss = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (sb_in_ready) begin n_iss++; if (t_iss < 0) t_iss = k; end
         if (rnd_done) begin t_done = k; got_res = rnd_result; rnd_req = 1'b0; end
         if (key_done) n_own++;
      end
      chk_i("midop stray done", n_own, 0);
      chk_i("midop reissue tick", t_iss, 1);
      chk_i("midop reissue pulses", n_iss, 1);
      chk_i("midop done tick", t_done, 4);
      chk("midop result", got_res, {16{8'h7C}});

      // Randomized traffic against a transaction-level model.
      reset = 1'b1; rnd_req = 1'b0; key_req = 1'b0; sbox_ready = 1'b1; cd = 0;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      last_key_m = 1'b0; err_m = 1'b0; inf = 1'b0; inf_key = 1'b0; inf_lat = 0; inf_op = '0; t0 = 0;
      rnd_pend = 1'b0; key_pend = 1'b0;
      for (int it = 0; it < 4000; it++) begin
         sbox_ready = ($urandom_range(0, 5) != 0);
         lat_cfg = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
         if (!rnd_pend) begin
            if ($urandom_range(0, 2) == 0) begin
               rnd_pend = 1'b1; rnd_req = 1'b1; rnd_data = {$urandom, $urandom, $urandom, $urandom};
            end
         end else if (inf && !inf_key && $urandom_range(0, 7) == 0) rnd_req = 1'b0;
         if (!key_pend) begin
            if ($urandom_range(0, 2) == 0) begin
               key_pend = 1'b1; key_req = 1'b1; key_word = $urandom;
            end
         end else if (inf && inf_key && $urandom_range(0, 7) == 0) key_req = 1'b0;

         p_idle = !rnd_gnt && !key_gnt; p_rr = rnd_req; p_kr = key_req; p_sr = sbox_ready;
         tick();

         exp_start = p_idle && p_sr && (p_rr || p_kr);
         chk("rand issue", 128'(sb_in_ready), 128'(exp_start));
         if (exp_start) begin
            inf = 1'b1;
            inf_key = p_kr && (!p_rr || !last_key_m);
            inf_op = inf_key ? {key_word, 96'b0} : rnd_data;
            inf_lat = lat_cfg;
            t0 = cyc;
         end
         exp_due = inf && ((cyc - t0) == ((inf_lat == 0) ? TIMEOUT + 1 : inf_lat + 1));
         chk("rand done", 128'({rnd_done, key_done}), exp_due ? (inf_key ? 128'b01 : 128'b10) : 128'b00);
         chk("rand gnt/busy", 128'({rnd_gnt, key_gnt, busy}), inf ? (inf_key ? 128'b011 : 128'b101) : 128'b000);
         if (inf) chk("rand operand", sb_in_data, inf_op);
         if (exp_due) begin
            exp_res = (inf_lat == 0) ? 128'h0 : sub128(inf_op);
            if (inf_lat == 0) err_m = 1'b1;
            if (inf_key) chk("rand key_result", 128'(key_result), 128'(exp_res[127:96]));
            else         chk("rand rnd_result", rnd_result, exp_res);
            chk("rand timeout_err", 128'(timeout_err), 128'(err_m));
            last_key_m = inf_key;
            inf = 1'b0;
            if (inf_key) begin
               if (!key_req || $urandom_range(0, 1) == 0) begin key_req = 1'b0; key_pend = 1'b0; end
            end else begin
               if (!rnd_req || $urandom_range(0, 1) == 0) begin rnd_req = 1'b0; rnd_pend = 1'b0; end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
